// File: rtl/multicycle_control_fsm.sv
// Control unit for a multicycle MIPS-like datapath: an 8-state Moore FSM plus
// opcode decode for the datapath selects, with only PCSrc looking at Zero.
module multicycle_control_fsm (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  output logic [2:0] State,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic       DataMemRW,
  output logic       ALUSrcB,
  output logic       DBDataSrc,
  output logic       WrRegDSrc,
  output logic       ExtSel,
  output logic [1:0] PCSrc,
  output logic [1:0] RegDst,
  output logic [2:0] ALUOp
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111,
    S_EXE_BR = 3'b101,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JR   = 2'b10;
  localparam logic [1:0] PCSRC_JUMP = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b110;

  state_t state_reg;
  state_t state_next;

  logic is_alu;
  logic is_beq;
  logic is_sw;
  logic is_lw;
  logic is_j;
  logic is_jr;
  logic is_jal;
  logic is_halt;

  // Instruction class decode
  always_comb begin
    is_alu  = 1'b0;
    is_beq  = 1'b0;
    is_sw   = 1'b0;
    is_lw   = 1'b0;
    is_j    = 1'b0;
    is_jr   = 1'b0;
    is_jal  = 1'b0;
    is_halt = 1'b0;
    case (Opcode)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLT: is_alu = 1'b1;
      OP_BEQ:  is_beq  = 1'b1;
      OP_SW:   is_sw   = 1'b1;
      OP_LW:   is_lw   = 1'b1;
      OP_J:    is_j    = 1'b1;
      OP_JR:   is_jr   = 1'b1;
      OP_JAL:  is_jal  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_reg <= S_IF;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = S_IF;
    case (state_reg)
      S_IF: state_next = S_ID;
      S_ID: begin
        if (is_alu)                    state_next = S_EXE_AL;
        else if (is_beq)               state_next = S_EXE_BR;
        else if (is_sw || is_lw)       state_next = S_EXE_LS;
        else if (is_halt)              state_next = S_ID;
        else                           state_next = S_IF;
      end
      S_EXE_AL: state_next = S_WB_AL;
      S_WB_AL:  state_next = S_IF;
      S_EXE_BR: state_next = S_IF;
      S_EXE_LS: state_next = S_MEM;
      S_MEM:    state_next = is_lw ? S_WB_LD : S_IF;
      S_WB_LD:  state_next = S_IF;
      default:  state_next = S_IF;
    endcase
  end

  // Write enables: held low while Reset is asserted so an abandoned
  // instruction never commits to PC, IR, registers or memory.
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    DataMemRW = 1'b0;
    if (Reset) begin
      case (state_reg)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          PCWre  = is_j || is_jr || is_jal;
          RegWre = is_jal;
        end
        S_WB_AL: begin
          PCWre  = 1'b1;
          RegWre = 1'b1;
        end
        S_EXE_BR: PCWre = 1'b1;
        S_MEM: begin
          PCWre     = is_sw;
          DataMemRW = is_sw;
        end
        S_WB_LD: begin
          PCWre  = 1'b1;
          RegWre = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath selects depend on opcode only, except the branch outcome.
  always_comb begin
    PCSrc     = PCSRC_SEQ;
    RegDst    = 2'b10;
    WrRegDSrc = 1'b1;
    DBDataSrc = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b1;
    ALUOp     = ALU_ADD;

    if (state_reg == S_EXE_BR)  PCSrc = Zero ? PCSRC_BR : PCSRC_SEQ;
    else if (is_j || is_jal)    PCSrc = PCSRC_JUMP;
    else if (is_jr)             PCSrc = PCSRC_JR;

    if (is_jal)
      RegDst = 2'b00;
    else if (Opcode == OP_ADDI || Opcode == OP_ORI || is_lw)
      RegDst = 2'b01;

    WrRegDSrc = !is_jal;
    DBDataSrc = is_lw;
    ALUSrcB   = (Opcode == OP_ADDI) || (Opcode == OP_ORI) || is_sw || is_lw;
    ExtSel    = (Opcode != OP_ORI);

    case (Opcode)
      OP_SUB, OP_BEQ: ALUOp = ALU_SUB;
      OP_OR, OP_ORI:  ALUOp = ALU_OR;
      OP_AND:         ALUOp = ALU_AND;
      OP_SLT:         ALUOp = ALU_SLT;
      default:        ALUOp = ALU_ADD;
    endcase
  end

  assign State = state_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class
// through its state sequence and checks enables and selects at every step.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'b000000;
  logic       zero = 1'b0;
  logic [2:0] state;
  logic       pc_wre, ir_wre, reg_wre, mem_rw;
  logic       alu_src_b, db_data_src, wr_reg_d_src, ext_sel;
  logic [1:0] pc_src, reg_dst;
  logic [2:0] alu_op;
  logic [3:0] we;

  int checks = 0;
  int failures = 0;

  assign we = {pc_wre, ir_wre, reg_wre, mem_rw};

  multicycle_control_fsm dut (
    .CLK(clk), .Reset(rst_n), .Opcode(opcode), .Zero(zero), .State(state),
    .PCWre(pc_wre), .IRWre(ir_wre), .RegWre(reg_wre), .DataMemRW(mem_rw),
    .ALUSrcB(alu_src_b), .DBDataSrc(db_data_src), .WrRegDSrc(wr_reg_d_src),
    .ExtSel(ext_sel), .PCSrc(pc_src), .RegDst(reg_dst), .ALUOp(alu_op)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; sample point is the following falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Pulse reset and leave the FSM in IF at a falling edge with opcode loaded.
  task automatic restart(input logic [5:0] op);
    @(negedge clk);
    rst_n  = 1'b0;
    opcode = op;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic walk(input string name, input logic [5:0] op, input int n,
                      input logic [2:0] es [6], input logic [3:0] ew [6]);
    restart(op);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      checks++;
      if (state !== es[i]) begin
        failures++;
        $display("FAIL %s_state[%0d] got=%b exp=%b", name, i, state, es[i]);
      end
      checks++;
      if (we !== ew[i]) begin
        failures++;
        $display("FAIL %s_we[%0d] got=%b exp=%b", name, i, we, ew[i]);
      end
      $display("%s step %0d: state=%b we=%b", name, i, state, we);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    opcode = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (state !== 3'b000 || we !== 4'b0000) begin
        failures++;
        $display("FAIL reset_hold got state=%b we=%b exp state=000 we=0000", state, we);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== 3'b000 || we !== 4'b0100) begin
      failures++;
      $display("FAIL reset_release got state=%b we=%b exp state=000 we=0100", state, we);
    end
    $display("reset: state=%b we=%b", state, we);
  endtask

  task automatic test_add();
    logic [2:0] es [6];
    logic [3:0] ew [6];
    es = '{3'b000, 3'b001, 3'b110, 3'b111, 3'b000, 3'b000};
    ew = '{4'b0100, 4'b0000, 4'b0000, 4'b1010, 4'b0100, 4'b0000};
    walk("add", 6'b000000, 5, es, ew);
    checks++;
    if (reg_dst !== 2'b10 || alu_op !== 3'b000 || alu_src_b !== 1'b0) begin
      failures++;
      $display("FAIL add_sel got regdst=%b aluop=%b srcb=%b exp 10 000 0", reg_dst, alu_op, alu_src_b);
    end
  endtask

  task automatic test_load_store();
    logic [2:0] es [6];
    logic [3:0] ew [6];
    es = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
    ew = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b0100};
    walk("lw", 6'b110001, 6, es, ew);
    checks++;
    if (db_data_src !== 1'b1 || alu_src_b !== 1'b1 || reg_dst !== 2'b01 || alu_op !== 3'b000) begin
      failures++;
      $display("FAIL lw_sel got db=%b srcb=%b regdst=%b aluop=%b exp 1 1 01 000",
               db_data_src, alu_src_b, reg_dst, alu_op);
    end
    es = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b000, 3'b000};
    ew = '{4'b0100, 4'b0000, 4'b0000, 4'b1001, 4'b0100, 4'b0000};
    walk("sw", 6'b110000, 5, es, ew);
    checks++;
    if (db_data_src !== 1'b0 || alu_src_b !== 1'b1) begin
      failures++;
      $display("FAIL sw_sel got db=%b srcb=%b exp 0 1", db_data_src, alu_src_b);
    end
  endtask

  task automatic test_beq();
    logic [2:0] es [6];
    logic [3:0] ew [6];
    es = '{3'b000, 3'b001, 3'b101, 3'b000, 3'b000, 3'b000};
    ew = '{4'b0100, 4'b0000, 4'b1000, 4'b0100, 4'b0000, 4'b0000};
    zero = 1'b1;
    walk("beq", 6'b110100, 3, es, ew);
    checks++;
    if (pc_src !== 2'b01 || alu_op !== 3'b001) begin
      failures++;
      $display("FAIL beq_taken got pcsrc=%b aluop=%b exp 01 001", pc_src, alu_op);
    end
    zero = 1'b0;
    #1;
    checks++;
    if (pc_src !== 2'b00 || pc_wre !== 1'b1) begin
      failures++;
      $display("FAIL beq_not_taken got pcsrc=%b pcwre=%b exp 00 1", pc_src, pc_wre);
    end
    $display("beq: zero=0 pcsrc=%b pcwre=%b", pc_src, pc_wre);
    step();
    checks++;
    if (state !== 3'b000) begin
      failures++;
      $display("FAIL beq_return got state=%b exp 000", state);
    end
  endtask

  task automatic test_jumps();
    logic [5:0] ops [3];
    logic [3:0] exp_we [3];
    logic [1:0] exp_pcsrc [3];
    logic [1:0] exp_dst [3];
    logic       exp_wrsrc [3];
    ops       = '{6'b111010, 6'b111000, 6'b111001};
    exp_we    = '{4'b1010, 4'b1000, 4'b1000};
    exp_pcsrc = '{2'b11, 2'b11, 2'b10};
    exp_dst   = '{2'b00, 2'b10, 2'b10};
    exp_wrsrc = '{1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      restart(ops[k]);
      step();
      checks++;
      if (state !== 3'b001 || we !== exp_we[k] || pc_src !== exp_pcsrc[k]
          || reg_dst !== exp_dst[k] || wr_reg_d_src !== exp_wrsrc[k]) begin
        failures++;
        $display("FAIL jump_%b_id got st=%b we=%b pcsrc=%b dst=%b wrsrc=%b exp 001 %b %b %b %b",
                 ops[k], state, we, pc_src, reg_dst, wr_reg_d_src,
                 exp_we[k], exp_pcsrc[k], exp_dst[k], exp_wrsrc[k]);
      end
      $display("jump %b: ID we=%b pcsrc=%b", ops[k], we, pc_src);
      step();
      checks++;
      if (state !== 3'b000) begin
        failures++;
        $display("FAIL jump_%b_next got state=%b exp 000", ops[k], state);
      end
    end
  endtask

  task automatic test_decode();
    logic [5:0] ops [7];
    logic [2:0] exp_alu [7];
    logic       exp_srcb [7];
    logic       exp_ext [7];
    logic [1:0] exp_dst [7];
    ops      = '{6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010, 6'b100110, 6'b000011};
    exp_alu  = '{3'b001, 3'b000, 3'b101, 3'b110, 3'b101, 3'b010, 3'b000};
    exp_srcb = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_ext  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_dst  = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};
    for (int k = 0; k < 7; k++) begin
      restart(ops[k]);
      step();
      checks++;
      if (alu_op !== exp_alu[k] || alu_src_b !== exp_srcb[k] || ext_sel !== exp_ext[k]
          || reg_dst !== exp_dst[k] || we !== 4'b0000) begin
        failures++;
        $display("FAIL decode_%b got aluop=%b srcb=%b ext=%b dst=%b we=%b exp %b %b %b %b 0000",
                 ops[k], alu_op, alu_src_b, ext_sel, reg_dst, we,
                 exp_alu[k], exp_srcb[k], exp_ext[k], exp_dst[k]);
      end
      step();
      checks++;
      // last entry is an undefined opcode, which returns to IF
      if (state !== ((k == 6) ? 3'b000 : 3'b110)) begin
        failures++;
        $display("FAIL decode_%b_next got state=%b", ops[k], state);
      end
      $display("decode %b: aluop=%b srcb=%b ext=%b next=%b", ops[k], alu_op, alu_src_b, ext_sel, state);
    end
  endtask

  task automatic test_halt();
    restart(6'b111111);
    for (int i = 0; i < 11; i++) begin
      step();
      checks++;
      if (state !== 3'b001 || we !== 4'b0000) begin
        failures++;
        $display("FAIL halt_hold[%0d] got state=%b we=%b exp 001 0000", i, state, we);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'b000 || we !== 4'b0000) begin
      failures++;
      $display("FAIL halt_async_reset got state=%b we=%b exp 000 0000", state, we);
    end
    $display("halt: async reset -> state=%b we=%b", state, we);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_in_mem();
    restart(6'b110000);
    step();
    step();
    step();
    checks++;
    if (state !== 3'b011 || mem_rw !== 1'b1) begin
      failures++;
      $display("FAIL sw_mem_reach got state=%b memrw=%b exp 011 1", state, mem_rw);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'b000 || mem_rw !== 1'b0 || we !== 4'b0000) begin
      failures++;
      $display("FAIL mem_reset got state=%b memrw=%b we=%b exp 000 0 0000", state, mem_rw, we);
    end
    $display("sw reset in MEM: state=%b memrw=%b", state, mem_rw);
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_store();
    test_beq();
    test_jumps();
    test_decode();
    test_halt();
    test_reset_in_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have parameter none; all encodings are fixed by this document.
REQ-002 SHALL have port CLK, input, 1, the single rising-edge clock.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port Opcode, input, 6, IR[31:26] of the instruction held in IR.
REQ-005 SHALL have port Zero, input, 1, ALU zero flag registered from the previous cycle.
REQ-006 SHALL have port State, output, 3, current FSM state.
REQ-007 SHALL have ports PCWre, IRWre, RegWre, DataMemRW, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel, each output, 1 bit, driving the PC/IR/register-file/data-memory write enables and the 32-bit two-input selectors.
REQ-008 SHALL have ports PCSrc (2 bits: 00 PC+4, 01 branch, 10 jr, 11 jump), RegDst (2 bits: 00 $31, 01 rt, 10 rd) and ALUOp (3 bits), all outputs.

Function
REQ-009 SHALL use these state encodings: IF=000, ID=001, EXE_AL=110, WB_AL=111, EXE_BR=101, EXE_LS=010, MEM=011, WB_LD=100.
REQ-010 SHALL decode these opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
REQ-011 SHALL advance the state once per CLK edge as follows:
 - IF->ID
 - ID->EXE_AL for add/sub/addi/or/and/ori/slt
 - ID->EXE_BR for beq
 - ID->EXE_LS for sw/lw
 - ID->IF for j/jr/jal
 - ID->ID for halt
 - any undefined opcode: ID->IF
 - EXE_AL->WB_AL->IF
 - EXE_BR->IF
 - EXE_LS->MEM
 - MEM->IF for sw
 - MEM->WB_LD for lw
 - WB_LD->IF
REQ-012 SHALL make all outputs combinational functions of State and Opcode (Moore/Mealy decode), with no output depending on Zero except PCSrc.
REQ-013 SHALL assert IRWre=1 only in IF.
REQ-014 SHALL assert PCWre=1 only in the final state of each instruction: ID for j/jr/jal, WB_AL, EXE_BR, MEM for sw, WB_LD; PCWre SHALL be 0 in ID for halt.
REQ-015 SHALL assert RegWre=1 only in WB_AL, WB_LD, and ID for jal.
REQ-016 SHALL assert DataMemRW=1 only in MEM for sw.
REQ-017 SHALL drive PCSrc=01 in EXE_BR when Zero=1, 00 when Zero=0, 11 for j/jal, 10 for jr, and 00 otherwise.
REQ-018 SHALL drive RegDst=00 for jal, 01 for addi/ori/lw, and 10 otherwise.
REQ-019 SHALL drive WrRegDSrc=0 for jal (write PC+4) and 1 otherwise.
REQ-020 SHALL drive DBDataSrc=1 for lw and 0 otherwise.
REQ-021 SHALL drive ALUSrcB=1 for addi/ori/sw/lw and 0 otherwise.
REQ-022 SHALL drive ExtSel=0 for ori and 1 otherwise.
REQ-023 SHALL drive ALUOp as: 000 add/addi/sw/lw; 001 sub/beq; 101 or/ori; 110 and; 010 slt; 000 otherwise.
REQ-024 SHALL hold in ID with halt, all write enables 0, until Reset is asserted.

Reset
REQ-025 SHALL, while Reset=0, force State=IF asynchronously, regardless of CLK.
REQ-026 SHALL, while Reset=0, hold PCWre=IRWre=RegWre=DataMemRW=0.
REQ-027 SHALL resume at IF on the first CLK edge after Reset rises.
REQ-028 SHALL, on a mid-instruction reset (e.g. in MEM), abandon the instruction with no register or memory write.

Verification
REQ-029 add: reset, Opcode=000000 -> states IF,ID,EXE_AL,WB_AL,IF; RegWre=1 and PCWre=1 only in WB_AL; RegDst=10.
REQ-030 lw: Opcode=110001 -> IF,ID,EXE_LS,MEM,WB_LD,IF; DBDataSrc=1; ALUSrcB=1; RegWre=1 only in WB_LD. sw: Opcode=110000 -> IF,ID,EXE_LS,MEM,IF with DataMemRW=1 in MEM.
REQ-031 beq: Opcode=110100 -> EXE_BR with PCSrc=01 for Zero=1 and PCSrc=00 for Zero=0; PCWre=1 in EXE_BR in both cases.
REQ-032 jal: Opcode=111010 -> ID drives PCSrc=11, RegDst=00, WrRegDSrc=0, RegWre=1, PCWre=1, next state IF.
REQ-033 halt: Opcode=111111 -> State stays 001 for 10 cycles with PCWre=0; Reset pulse -> State=000 immediately without a clock edge.
REQ-034 Reset asserted while in MEM for sw -> State=000 and DataMemRW=0 in the same cycle.
